bch_dec_arb: RTL and testbench

//  Shares one combinational BCH(41,31) decoder (dec_top) between two codeword

---
 rtl/bch_dec_arb.sv | 119 +++++++++++
 tb/tb_bch_dec_arb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bch_dec_arb.sv
// Two-requester round-robin front end for a shared combinational BCH(41,31) decoder.
// Holds one registered, id-tagged response and saturating corrected/uncorrectable counters.
module bch_dec_arb #(
  parameter int unsigned CW_W   = 41,
  parameter int unsigned DATA_W = 31,
  parameter int unsigned SYN_W  = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [CW_W-1:0]   req0_cw,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [CW_W-1:0]   req1_cw,
  output logic              req1_ready,
  output logic [CW_W-1:0]   dec_in,
  input  logic [DATA_W-1:0] dec_out,
  input  logic [SYN_W-1:0]  dec_syn,
  input  logic              dec_err,
  input  logic              dec_sgl,
  input  logic              dec_dbl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [SYN_W-1:0]  rsp_syn,
  output logic              rsp_sgl,
  output logic              rsp_dbl,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  sgl_cnt,
  output logic [CNT_W-1:0]  dbl_cnt
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic               last_gnt_q;
  logic               rsp_id_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [SYN_W-1:0]   rsp_syn_q;
  logic               rsp_sgl_q, rsp_dbl_q;
  logic [CNT_W-1:0]   sgl_cnt_q, sgl_cnt_d;
  logic [CNT_W-1:0]   dbl_cnt_q, dbl_cnt_d;

  logic slot_free, any_valid, gnt, accept, new_dbl;

  assign any_valid = req0_valid | req1_valid;
  // On a tie the requester that did not win last time gets the slot.
  assign gnt       = (req0_valid & req1_valid) ? ~last_gnt_q : req1_valid;
  assign slot_free = (state_q == StEmpty) | rsp_ready;
  assign accept    = slot_free & any_valid;

  assign req0_ready = accept & ~gnt;
  assign req1_ready = accept & gnt;

  // All-zero is a valid codeword, so an idle decoder input raises no error.
  assign dec_in = !any_valid ? '0 : (gnt ? req1_cw : req0_cw);

  // A nonzero syndrome that the decoder did not correct is uncorrectable.
  assign new_dbl = dec_dbl | (dec_err & ~dec_sgl);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (rsp_ready && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    sgl_cnt_d = sgl_cnt_q;
    dbl_cnt_d = dbl_cnt_q;
    if (clr_cnt) begin
      sgl_cnt_d = '0;
      dbl_cnt_d = '0;
    end else if (accept) begin
      if (dec_sgl && !(&sgl_cnt_q)) sgl_cnt_d = sgl_cnt_q + 1'b1;
      if (new_dbl && !(&dbl_cnt_q)) dbl_cnt_d = dbl_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      last_gnt_q <= 1'b1;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_syn_q  <= '0;
      rsp_sgl_q  <= 1'b0;
      rsp_dbl_q  <= 1'b0;
      sgl_cnt_q  <= '0;
      dbl_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      sgl_cnt_q <= sgl_cnt_d;
      dbl_cnt_q <= dbl_cnt_d;
      if (accept) begin
        last_gnt_q <= gnt;
        rsp_id_q   <= gnt;
        rsp_data_q <= dec_out;
        rsp_syn_q  <= dec_syn;
        rsp_sgl_q  <= dec_sgl;
        rsp_dbl_q  <= new_dbl;
      end
    end
  end

  assign rsp_valid = (state_q == StFull);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_syn   = rsp_syn_q;
  assign rsp_sgl   = rsp_sgl_q;
  assign rsp_dbl   = rsp_dbl_q;
  assign sgl_cnt   = sgl_cnt_q;
  assign dbl_cnt   = dbl_cnt_q;

endmodule

// File: tb/tb_bch_dec_arb.sv
// Directed bench for bch_dec_arb with a toy stand-in for dec_top: cw[40:31] acts as the
// syndrome (0 clean, [9:8]=00 single error at data bit syn[4:0]-1, [9]=1 double, 01 error only).
module tb_bch_dec_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [40:0] req0_cw, req1_cw, dec_in;
  logic [30:0] dec_out;
  logic [9:0]  dec_syn;
  logic        dec_err, dec_sgl, dec_dbl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_sgl, rsp_dbl;
  logic [30:0] rsp_data;
  logic [9:0]  rsp_syn;
  logic        clr_cnt;
  logic [15:0] sgl_cnt, dbl_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bch_dec_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_cw   (req0_cw),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_cw   (req1_cw),
    .req1_ready(req1_ready),
    .dec_in    (dec_in),
    .dec_out   (dec_out),
    .dec_syn   (dec_syn),
    .dec_err   (dec_err),
    .dec_sgl   (dec_sgl),
    .dec_dbl   (dec_dbl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_syn   (rsp_syn),
    .rsp_sgl   (rsp_sgl),
    .rsp_dbl   (rsp_dbl),
    .clr_cnt   (clr_cnt),
    .sgl_cnt   (sgl_cnt),
    .dbl_cnt   (dbl_cnt)
  );

  always_comb begin
    dec_syn = dec_in[40:31];
    dec_err = |dec_syn;
    dec_sgl = dec_err && (dec_syn[9:8] == 2'b00);
    dec_dbl = dec_syn[9];
    dec_out = dec_in[30:0];
    if (dec_sgl && dec_syn[4:0] != 5'd0) dec_out = dec_in[30:0] ^ (31'd1 << (dec_syn[4:0] - 5'd1));
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_cw = '0; req1_cw = '0;
    rsp_ready = 1'b1; clr_cnt = 1'b0;
    step(); step();
    rst = 1'b0;

    // 1: reset state and first transaction
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_sgl_cnt", sgl_cnt, 0);
    check("rst_dbl_cnt", dbl_cnt, 0);
    req0_valid = 1; req0_cw = '0;
    #1;
    check("t1_req0_ready", req0_ready, 1);
    check("t1_req1_ready", req1_ready, 0);
    check("t1_dec_in", dec_in, 0);
    step();
    req0_valid = 0;
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_id", rsp_id, 0);
    check("t1_rsp_data", rsp_data, 0);
    check("t1_rsp_flags", {rsp_sgl, rsp_dbl}, 0);

    // 2: round robin, back-to-back, from a fresh reset
    rst = 1; step(); rst = 0;
    req0_valid = 1; req0_cw = {10'd0, 31'h0A};
    req1_valid = 1; req1_cw = {10'd0, 31'h0B};
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t2_req0_ready", req0_ready, (i % 2) == 0);
      check("t2_req1_ready", req1_ready, (i % 2) == 1);
      step();
      check("t2_rsp_valid", rsp_valid, 1);
      check("t2_rsp_id", rsp_id, i % 2);
      check("t2_rsp_data", rsp_data, (i % 2) ? 31'h0B : 31'h0A);
    end
    req0_valid = 0; req1_valid = 0;
    step();
    check("t2_drain", rsp_valid, 0);

    // 3: single error on req1 (data 1, bit 0 flipped)
    req1_valid = 1; req1_cw = {10'd1, 31'd0};
    #1;
    check("t3_req1_ready", req1_ready, 1);
    step();
    req1_valid = 0;
    check("t3_rsp_id", rsp_id, 1);
    check("t3_rsp_data", rsp_data, 1);
    check("t3_rsp_sgl", rsp_sgl, 1);
    check("t3_rsp_dbl", rsp_dbl, 0);
    check("t3_syn_nonzero", rsp_syn != 0, 1);
    check("t3_sgl_cnt", sgl_cnt, 1);
    check("t3_dbl_cnt", dbl_cnt, 0);
    step();
    check("t3_drain", rsp_valid, 0);

    // 4: double error, stall for 3 cycles, then drain
    rsp_ready = 0;
    req1_valid = 1; req1_cw = {10'h203, 31'd2};
    #1;
    check("t4_req1_ready", req1_ready, 1);
    step();
    req1_valid = 0;
    req0_valid = 1; req0_cw = {10'd0, 31'h55};
    check("t4_rsp_dbl", rsp_dbl, 1);
    check("t4_rsp_sgl", rsp_sgl, 0);
    check("t4_rsp_data", rsp_data, 2);
    check("t4_dbl_cnt", dbl_cnt, 1);
    check("t4_sgl_cnt", sgl_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_stall_ready", {req0_ready, req1_ready}, 0);
      check("t4_stall_valid", rsp_valid, 1);
      check("t4_stall_data", rsp_data, 2);
      check("t4_stall_id", rsp_id, 1);
      step();
    end
    rsp_ready = 1;
    #1;
    check("t4_resume_ready", req0_ready, 1);
    step();
    check("t4_next_data", rsp_data, 31'h55);
    check("t4_next_flags", {rsp_sgl, rsp_dbl}, 0);
    // error flagged but neither single nor double: still uncorrectable
    req0_cw = {10'h100, 31'h7};
    step();
    req0_valid = 0;
    check("t4_erronly_dbl", rsp_dbl, 1);
    check("t4_erronly_data", rsp_data, 7);
    check("t4_erronly_cnt", dbl_cnt, 2);
    step();
    check("t4_drain", rsp_valid, 0);

    // 5: sgl_cnt saturation, then clear beating a same-cycle increment
    req0_valid = 1; req0_cw = {10'd1, 31'd0};
    repeat (65534) step();
    check("t5_sgl_full", sgl_cnt, 16'hFFFF);
    step();
    check("t5_sgl_sat", sgl_cnt, 16'hFFFF);
    clr_cnt = 1;
    step();
    clr_cnt = 0;
    check("t5_clr_sgl", sgl_cnt, 0);
    check("t5_clr_dbl", dbl_cnt, 0);
    req0_valid = 0;
    step();

    // 6: reset with a full slot and both requesters valid
    rsp_ready = 0;
    req0_valid = 1; req0_cw = {10'd0, 31'h11};
    step();
    check("t6_full", rsp_valid, 1);
    req1_valid = 1; req1_cw = {10'd0, 31'h22};
    rst = 1;
    step();
    rst = 0;
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_rsp_data", rsp_data, 0);
    #1;
    check("t6_tie_req0", {req0_ready, req1_ready}, 2'b10);
    rsp_ready = 1;
    step();
    req0_valid = 0; req1_valid = 0;
    check("t6_rsp_id", rsp_id, 0);
    check("t6_rsp_data2", rsp_data, 31'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
